// File: rtl/pwm_bank_pkg.sv
// rtl/pwm_bank_pkg.sv - shared types and helpers for the pwm_bank block
package pwm_bank_pkg;

    // Load sequencer states: waiting for start, filling shadow bank, bank ready to commit
    typedef enum logic [1:0] {
        L_IDLE,
        L_FILL,
        L_PEND
    } load_state_e;

    // Period counter direction (DOWN only used by the center-aligned build)
    typedef enum logic {
        UP,
        DOWN
    } dir_e;

    // Full-scale count for a given duty/counter width
    function automatic int unsigned max_of(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// rtl/pwm_bank_if.sv - duty word load handshake between a source and pwm_bank
// Signals:
//   start    - marks the channel 0 word of a load (qualified by in_valid)
//   in_valid - duty word valid
//   in_ready - sink accepts a word when in_valid && in_ready
//   data     - duty word, channel order 0..CH-1
interface pwm_bank_if #(
    parameter int DWIDTH = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] data;

    modport master (output start, output in_valid, output data, input in_ready);
    modport slave  (input start, input in_valid, input data, output in_ready);
endinterface

// File: rtl/pwm_bank_timebase.sv
// rtl/pwm_bank_timebase.sv - prescaler plus shared PWM period counter
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   en           - run enable; when low prescaler and counter are held at 0
//   div          - tick every div+1 clocks, latched at period boundaries
//   center       - (PWM_CENTER_ALIGN_EN only) up/down counting, latched at boundaries
//   tick         - prescaler tick strobe
//   cnt          - current period count
//   boundary     - the tick that ends a period (counter returns to 0)
module pwm_bank_timebase
    import pwm_bank_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic               center,
`endif
    output logic               tick,
    output logic [DWIDTH-1:0]  cnt,
    output logic               boundary
);

    localparam logic [DWIDTH-1:0] MAXV = DWIDTH'(max_of(DWIDTH));

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] div_q, div_d;
    logic [DWIDTH-1:0]  cnt_q, cnt_d;
`ifdef PWM_CENTER_ALIGN_EN
    logic center_q, center_d;
    dir_e dir_q, dir_d;
`endif

    always_comb begin
        tick = en && (presc_q == div_q);
`ifdef PWM_CENTER_ALIGN_EN
        if (center_q) boundary = tick && (dir_q == DOWN) && (cnt_q == DWIDTH'(1));
        else          boundary = tick && (cnt_q == MAXV);
        center_d = center_q;
        dir_d    = dir_q;
`else
        boundary = tick && (cnt_q == MAXV);
`endif
        presc_d = presc_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        if (!en) begin
            // Idle: keep following div so a restart uses the current setting
            presc_d = '0;
            cnt_d   = '0;
            div_d   = div;
`ifdef PWM_CENTER_ALIGN_EN
            center_d = center;
            dir_d    = UP;
`endif
        end else if (!tick) begin
            presc_d = presc_q + PRESC_W'(1);
        end else begin
            presc_d = '0;
            if (boundary) begin
                // Period settings only change here, so no runt periods
                cnt_d = '0;
                div_d = div;
`ifdef PWM_CENTER_ALIGN_EN
                center_d = center;
                dir_d    = UP;
`endif
            end else begin
`ifdef PWM_CENTER_ALIGN_EN
                if (center_q && (dir_q == DOWN)) begin
                    cnt_d = cnt_q - DWIDTH'(1);
                end else if (center_q && (cnt_q == MAXV)) begin
                    cnt_d = MAXV - DWIDTH'(1);
                    dir_d = DOWN;
                end else begin
                    cnt_d = cnt_q + DWIDTH'(1);
                end
`else
                cnt_d = cnt_q + DWIDTH'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            center_q <= 1'b0;
            dir_q    <= UP;
`endif
        end else begin
            presc_q <= presc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
`ifdef PWM_CENTER_ALIGN_EN
            center_q <= center_d;
            dir_q    <= dir_d;
`endif
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - multi-channel PWM with atomically committed duty bank
// Ports:
//   clk, rst - clock, asynchronous active-low reset
//   en       - run enable for counter and outputs
//   div      - prescaler divider (tick every div+1 clocks)
//   center   - (PWM_CENTER_ALIGN_EN only) center-aligned mode select
//   bus      - duty word load handshake (pwm_bank_if slave)
//   out      - PWM outputs, out[i] for channel i
//   hsync    - one-clock strobe on the first output cycle of a new bank
//   busy     - load in progress or bank waiting to commit
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int CH      = 8,
    parameter int DWIDTH  = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic               center,
`endif
    pwm_bank_if.slave          bus,
    output logic [0:CH-1]      out,
    output logic               hsync,
    output logic               busy
);

    localparam int IDXW = (CH > 1) ? $clog2(CH) : 1;

    load_state_e       state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [DWIDTH-1:0] shadow_q [CH];
    logic [DWIDTH-1:0] shadow_d [CH];
    logic [DWIDTH-1:0] active_q [CH];
    logic [DWIDTH-1:0] active_d [CH];
    logic [0:CH-1]     out_q, out_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              sync_q, sync_d;
    logic              hsync_q, hsync_d;
    logic              accept, commit, tick, boundary;
    logic [DWIDTH-1:0] cnt;

    pwm_bank_timebase #(
        .DWIDTH  (DWIDTH),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
`ifdef PWM_CENTER_ALIGN_EN
        .center   (center),
`endif
        .tick     (tick),
        .cnt      (cnt),
        .boundary (boundary)
    );

    always_comb begin
        accept = bus.in_valid && in_ready_q;
        // With the counter stopped there is no boundary to wait for
        commit   = (state_q == L_PEND) && (!en || (tick && boundary));
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        unique case (state_q)
            L_IDLE: begin
                if (accept && bus.start) begin
                    shadow_d[0] = bus.data;
                    idx_d       = IDXW'(1);
                    if (CH == 1) state_d = L_PEND;
                    else         state_d = L_FILL;
                end
            end
            L_FILL: begin
                if (accept) begin
                    if (bus.start) begin
                        // A new start abandons the partial bank
                        shadow_d[0] = bus.data;
                        idx_d       = IDXW'(1);
                    end else begin
                        shadow_d[idx_q] = bus.data;
                        if (idx_q == IDXW'(CH - 1)) state_d = L_PEND;
                        else                        idx_d   = idx_q + IDXW'(1);
                    end
                end
            end
            L_PEND: begin
                if (commit) begin
                    active_d = shadow_q;
                    state_d  = L_IDLE;
                end
            end
            default: state_d = L_IDLE;
        endcase
        in_ready_d = (state_d != L_PEND);
        busy_d     = (state_d != L_IDLE);
        // Two stages so hsync lines up with the registered cnt=0 outputs
        sync_d  = commit;
        hsync_d = sync_q;
        for (int i = 0; i < CH; i++) out_d[i] = en && (cnt < active_q[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= L_IDLE;
            idx_q      <= '0;
            for (int i = 0; i < CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            out_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sync_q     <= 1'b0;
            hsync_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            out_q      <= out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            sync_q     <= sync_d;
            hsync_q    <= hsync_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign out          = out_q;
    assign hsync        = hsync_q;
    assign busy         = busy_q;

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
Parametrised multi-channel PWM generator; successor to the 8-stage/8-bit PWM, now on one clock.
- Duty words stream in serially through a valid/ready handshake into a shadow bank.
- The bank commits atomically at a period boundary.
- Drives CH PWM outputs from a shared prescaled period counter.
- Emits hsync on the first period that uses a newly committed bank.

Parameters:
CH, 8, number of PWM channels (>=1)
DWIDTH, 8, duty/counter width; MAX = 2**DWIDTH-1
PRESC_W, 4, prescaler divider width

Ports:
clk  in  1  single clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
en  in  1  run enable for period counter/outputs
div  in  PRESC_W  tick every div+1 clocks; sampled at each period boundary
start  in  1  qualifies first word of a load (channel 0); valid only with in_valid
in_valid  in  1  duty word valid
in_ready  out  1  block accepts word when in_valid&&in_ready
data  in  DWIDTH  duty word, channel order 0..CH-1
out  out  [0:CH-1]  PWM outputs, out[i] for channel i
hsync  out  1  one-clock strobe: new bank active
busy  out  1  load in progress or bank pending

Behaviour:
- Reset (rst=0, async): counter=0, prescaler=0, active and shadow banks=0, load FSM=L_IDLE, out=0, hsync=0, in_ready=0, busy=0.
- Load FSM:
  - L_IDLE: in_ready=1. Words without start are ignored. A word with start writes shadow[0] and goes to L_FILL with idx=1.
  - L_FILL: in_ready=1. Each accepted word writes shadow[idx], idx++. After shadow[CH-1] goes to L_PEND. CH=1 goes directly from L_IDLE to L_PEND.
  - start seen in L_FILL: that word writes shadow[0], idx=1, partial bank discarded.
  - L_PEND: in_ready=0, busy=1. On commit, active<=shadow and go to L_IDLE.
  - busy=1 in L_FILL and L_PEND.
- Prescaler: tick when presc==div, then presc=0; otherwise presc++. div=0 gives a tick every clock.
- Period counter (edge-aligned): advances on tick 0..MAX, wraps to 0. Period = 2**DWIDTH ticks.
- Output: out[i] = en && (cnt < active[i]), registered, one clock latency from cnt.
  - Duty 0: never high.
  - Duty MAX: high MAX of 2**DWIDTH ticks.
  - High clocks per period = active[i]*(div+1).
- Boundary: the tick on which cnt wraps MAX->0.
  - Commit happens on the clock of the boundary tick when in L_PEND.
  - hsync=1 on the following clock, for exactly one clock, aligned with the first output cycle of cnt=0.
- en=0: counter and prescaler held at 0, out=0. A pending bank commits on the next clock and hsync pulses. Re-assert en: period starts at cnt=0 with the committed bank.
- Commit and accepted start on the same clock: cannot occur, because in_ready=0 in L_PEND.
- Changing div takes effect only at the next boundary, avoiding runt periods.
- Reset mid-load or mid-run: everything returns to reset values immediately; the partial bank is lost.

Optional Feature:
Macro PWM_CENTER_ALIGN_EN.
- Defined: adds input port center (1 bit), sampled at boundary.
  - center=1 selects up-down counting 0..MAX then MAX-1..1, period 2*MAX ticks.
  - Boundary is the MAX-1..1 -> 0 transition.
  - High ticks = 2*d-1 for 1<=d<=MAX; 0 for d=0.
- Undefined: no center port, edge-aligned only; logic removed.

Decomposition:
- Package pwm_bank_pkg: load FSM enum (L_IDLE, L_FILL, L_PEND), counter-direction enum (UP, DOWN), localparam function for MAX.
- One sub-module pwm_bank_timebase: prescaler plus period counter.
  - Outputs: tick, cnt, boundary.
  - Optional up/down under PWM_CENTER_ALIGN_EN.
- Top holds the load FSM, shadow/active banks and per-channel comparators.

Test Plan:
- CH=8, DWIDTH=8, div=0. Load 10,20,30,40,50,60,70,80 hex with start on word 0.
  -> hsync one clock at next boundary.
  -> per-period high clocks = 16,32,48,...,128.
  -> in_ready=0 between last word and commit.
- Load 00,FF,01,FE,00,FF,80,7F.
  -> out[0]=out[4]=0 always.
  -> out[1] high 255 of 256 clocks.
  -> out[2] high 1 clock.
  -> out[6] high 128 clocks.
- div=3, duty[0]=0x10 -> out[0] high 64 of 1024 clocks. Change div to 0 mid-period -> current period stays 1024 clocks, next is 256.
- Send 3 words, then start with 0x05 followed by 7 more words -> channel 0 duty=5, earlier partial words discarded, single hsync.
- Running with bank committed, pulse rst low for 1 clock -> out=0 and busy=0 immediately. hsync stays 0 until a full new load commits.
- With PWM_CENTER_ALIGN_EN, center=1, duty=0x10 -> out high 31 clocks per 510-clock period, centered on cnt=0.
